mc_timing_gen: RTL and testbench
================================

// Module: mc_timing_gen
// PURPOSE
//  MCS-51 machine-cycle timing generator: divides CLK (oscillator) into 12-clock machine cycles S1P1..S6P2.
//  Emits one-hot state and phase, ALE, a machine-cycle index and an instruction-start strobe.
//  Sits directly upstream of the core's flip-flop stages (IR, PC, ACC latches), which load on its strobes.
// PARAMETERS
//  NSTATE   6   states per machine cycle; 2 phases each, so the counter runs 0..2*NSTATE-1.
//  CYC_W    2   width of the machine-cycle index and the NCYC input.
// PORTS
//  CLK          in   1      oscillator clock; all state updates on posedge.
//  RSTdash      in   1      asynchronous, active-low reset.
//  NCYC         in   CYC_W  machine cycles of the current instruction minus 1; sampled at S2P2 of cycle 0.
//  MOVX         in   1      current instruction is MOVX; sampled with NCYC.
//  IDL          in   1      idle request (PCON.IDL); used only with MCS51_IDLE_EN.
//  WAKE         in   1      idle exit (interrupt or reset request); used only with MCS51_IDLE_EN.
//  STATE        out  NSTATE one-hot S1..S6; bit0 = S1.
//  P2           out  1      0 = phase 1, 1 = phase 2.
//  ALE          out  1      address latch enable.
//  CYC          out  CYC_W  machine-cycle index within the instruction.
//  LAST_CYC     out  1      CYC == latched NCYC.
//  INSTR_START  out  1      single-CLK pulse at S1P1 of cycle 0.
//  IDLE_ACK     out  1      high while frozen in idle.
// BEHAVIOUR
//  - Internal counter cnt 0..11: STATE = onehot(cnt>>1), P2 = cnt[0]. Wraps 11 -> 0.
//  - Outputs are registered, decoded from next-state. They change on the same edge as cnt, with no extra latency.
//  - Reset (RSTdash=0, async): cnt=0, CYC=0, ncyc_r=0, movx_r=0, idle=0.
//    Outputs: STATE=6'b000001, P2=0, ALE=0, LAST_CYC=1, INSTR_START=1, IDLE_ACK=0.
//  - Reset released mid-cycle: the sequence restarts from S1P1 cycle 0. No partial cycle is emitted.
//  - ALE=1 for cnt in {1,2} (S1P2,S2P1) and {7,8} (S4P2,S5P1), otherwise 0.
//  - NCYC/MOVX latch: on the edge leaving cnt=3 while CYC=0.
//  - Re-arm: on the edge entering S1P1 of cycle 0, ncyc_r/movx_r clear to 0 (1-cycle, no MOVX).
//  - Cycle advance: on the edge 11->0, CYC <= LAST_CYC ? 0 : CYC+1. INSTR_START=1 for exactly the following CLK when CYC becomes 0.
//  - LAST_CYC is combinational-free (registered). It is valid for the whole cycle from S3P1 of cycle 0 onward; in S1/S2 of cycle 0 it reads 1.
//  - CYC never exceeds ncyc_r. NCYC=2'b11 yields 4 cycles, CYC 0..3.
//  - MOVX suppression when movx_r=1 and ncyc_r>=1: ALE held 0 for the S4P2/S5P1 pulse of cycle 0 and the S1P2/S2P1 pulse of cycle 1.
//    All other pulses are normal. movx_r=1 with ncyc_r=0 has no effect.
//  - Idle mode: see CONFIGURATION.
//  - Simultaneous idle entry and WAKE: WAKE wins, so idle is not entered.
// CONFIGURATION
//  Macro MCS51_IDLE_EN.
//  - Defined:
//    - IDL is sampled on the edge 11->0 when LAST_CYC=1. If set, cnt freezes at 0, CYC=0, STATE=S1, P2=0, ALE=1, IDLE_ACK=1, and INSTR_START is held 0.
//    - WAKE=1 in idle: on the next edge, idle=0 and INSTR_START=1 (cnt=0), then normal sequencing resumes.
//    - RSTdash=0 also exits idle.
//  - Undefined: IDL and WAKE are ignored, IDLE_ACK is tied 0, and no idle state register exists.
// STRUCTURE
//  - Package mcs51_timing_pkg:
//    - Constants: MC_CLKS=12; S1..S6 one-hot constants; ALE_SLOT_A={1,2}; ALE_SLOT_B={7,8}; NCYC_LATCH_CNT=3.
//    - Typedef mc_state_t (6-bit one-hot).
//  - Sub-module mc_phase_ctr: mod-12 counter with freeze enable. Outputs cnt, wrap, and next_cnt.
//  - Top level: cycle index, latches, ALE/strobe decode, idle FSM (two states: RUN, IDLE).
// TESTING
//  1. Reset, then NCYC=0 for 36 CLK -> STATE steps S1..S6 every 2 CLK; INSTR_START pulses at CLK 0, 12, 24; ALE high at CLK 1,2,7,8 mod 12.
//  2. NCYC=2'b01 latched at S2P2 -> CYC=0,1,0; LAST_CYC=1 only in cycle 1 (from S3P1 of cycle 0: 0); INSTR_START period 24 CLK.
//  3. NCYC=2'b01, MOVX=1 -> exactly 2 ALE pulses in 24 CLK (cycle0 S1P2 and cycle1 S4P2); MOVX=1, NCYC=0 -> 2 pulses/12 CLK.
//  4. RSTdash low for 1 CLK at S4P1 of cycle 1 of a 4-cycle instruction -> immediate STATE=S1, CYC=0, ALE=0; INSTR_START on release.
//  5. MCS51_IDLE_EN: IDL=1 at last cycle -> frozen S1P1, ALE=1, IDLE_ACK=1 for 50 CLK; WAKE=1 -> next CLK IDLE_ACK=0, INSTR_START=1, S1P2 after.
//  6. Without macro: IDL=1 and WAKE toggling -> sequence identical to test 1; IDLE_ACK stays 0.

Source files
------------

// File: rtl/mc_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// mcs51_timing_pkg
// Shared constants and types for the MCS-51 machine-cycle timing generator.
// A machine cycle is 6 states (S1..S6) of 2 phases each, i.e. 12 oscillator
// clocks. The phase counter runs 0..11. STATE is onehot(cnt>>1) and P2 is cnt[0].
// Optional feature macro used by the generator: MCS51_IDLE_EN.
// -----------------------------------------------------------------------------
package mcs51_timing_pkg;

  localparam int NSTATE  = 6;             // states per machine cycle
  localparam int CYC_W   = 2;             // machine-cycle index / NCYC width
  localparam int MC_CLKS = 2 * NSTATE;    // oscillator clocks per machine cycle
  localparam int CNT_W   = $clog2(MC_CLKS);

  typedef logic [NSTATE-1:0] mc_state_t;  // one-hot S1..S6, bit0 = S1
  typedef logic [CNT_W-1:0]  mc_cnt_t;

  localparam mc_state_t S1 = 6'b000001;
  localparam mc_state_t S2 = 6'b000010;
  localparam mc_state_t S3 = 6'b000100;
  localparam mc_state_t S4 = 6'b001000;
  localparam mc_state_t S5 = 6'b010000;
  localparam mc_state_t S6 = 6'b100000;

  localparam mc_cnt_t CNT_LAST = mc_cnt_t'(MC_CLKS - 1);

  // ALE pulse positions: S1P2/S2P1 and S4P2/S5P1
  localparam logic [1:0][CNT_W-1:0] ALE_SLOT_A = {mc_cnt_t'(2), mc_cnt_t'(1)};
  localparam logic [1:0][CNT_W-1:0] ALE_SLOT_B = {mc_cnt_t'(8), mc_cnt_t'(7)};

  // NCYC/MOVX are captured on the edge leaving S2P2
  localparam mc_cnt_t NCYC_LATCH_CNT = mc_cnt_t'(3);

  // Idle controller states
  typedef enum logic {RUN = 1'b0, IDLE = 1'b1} idle_state_t;

  function automatic mc_state_t cnt_to_state(input mc_cnt_t cnt);
    return S1 << (cnt >> 1);
  endfunction

  function automatic logic in_slot(input mc_cnt_t cnt, input logic [1:0][CNT_W-1:0] slot);
    return (cnt == slot[0]) || (cnt == slot[1]);
  endfunction

endpackage

// File: rtl/mc_timing_gen_if.sv
// -----------------------------------------------------------------------------
// mc_timing_gen_if
// Bundle between the timing generator and the CPU core.
//   Core -> generator : NCYC, MOVX, IDL, WAKE
//   Generator -> core : STATE, P2, ALE, CYC, LAST_CYC, INSTR_START, IDLE_ACK
// Modports: master = core side, slave = timing generator.
// -----------------------------------------------------------------------------
interface mc_timing_gen_if;
  import mcs51_timing_pkg::*;

  logic [CYC_W-1:0] NCYC;
  logic             MOVX;
  logic             IDL;
  logic             WAKE;
  mc_state_t        STATE;
  logic             P2;
  logic             ALE;
  logic [CYC_W-1:0] CYC;
  logic             LAST_CYC;
  logic             INSTR_START;
  logic             IDLE_ACK;

  modport master (
    output NCYC, MOVX, IDL, WAKE,
    input  STATE, P2, ALE, CYC, LAST_CYC, INSTR_START, IDLE_ACK
  );

  modport slave (
    input  NCYC, MOVX, IDL, WAKE,
    output STATE, P2, ALE, CYC, LAST_CYC, INSTR_START, IDLE_ACK
  );
endinterface

// File: rtl/mc_timing_gen_phase_ctr.sv
// -----------------------------------------------------------------------------
// mc_phase_ctr
// Mod-12 phase counter (S1P1..S6P2) with a freeze enable.
//   clk      in   oscillator clock
//   rst_n    in   asynchronous active-low reset (counter -> 0)
//   freeze   in   hold the counter at its current value
//   cnt      out  current phase count 0..11
//   wrap     out  this edge takes the counter 11 -> 0
//   next_cnt out  value the counter takes on the next edge
// -----------------------------------------------------------------------------
module mc_phase_ctr
  import mcs51_timing_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    freeze,
  output mc_cnt_t cnt,
  output logic    wrap,
  output mc_cnt_t next_cnt
);

  mc_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign next_cnt = cnt_d;
  assign wrap     = !freeze && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mc_timing_gen.sv
// -----------------------------------------------------------------------------
// mc_timing_gen
// MCS-51 machine-cycle timing generator. Divides the oscillator into 12-clock
// machine cycles and produces the strobes the core's IR/PC/ACC latches use.
//   CLK      in   oscillator clock, rising edge
//   RSTdash  in   asynchronous active-low reset
//   bus      slave side of mc_timing_gen_if:
//            NCYC/MOVX (sampled at S2P2 of cycle 0), IDL/WAKE (idle control),
//            STATE, P2, ALE, CYC, LAST_CYC, INSTR_START, IDLE_ACK
// All outputs are flops loaded from the next-state decode, so they change on
// the same edge as the phase counter.
// Optional feature: define MCS51_IDLE_EN to enable the idle freeze (IDL/WAKE).
// Without it IDL and WAKE are ignored and IDLE_ACK is tied low.
// -----------------------------------------------------------------------------
module mc_timing_gen
  import mcs51_timing_pkg::*;
(
  input  logic           CLK,
  input  logic           RSTdash,
  mc_timing_gen_if.slave bus
);

  mc_cnt_t          cnt, next_cnt;
  logic             wrap, freeze;
  logic [CYC_W-1:0] cyc_q, cyc_d, ncyc_q, ncyc_d;
  logic             movx_q, movx_d;
  mc_state_t        state_q, state_d;
  logic             p2_q, p2_d, ale_q, ale_d, last_q, last_d, istart_q, istart_d;
  logic             idle_now, idle_next;

`ifdef MCS51_IDLE_EN
  idle_state_t idle_q, idle_d;

  // Idle is entered only at the end of an instruction; WAKE on the same edge
  // takes priority so idle is never entered then.
  always_comb begin
    idle_d = idle_q;
    case (idle_q)
      RUN:     if (wrap && last_q && bus.IDL && !bus.WAKE) idle_d = IDLE;
      IDLE:    if (bus.WAKE) idle_d = RUN;
      default: idle_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) idle_q <= RUN;
    else          idle_q <= idle_d;
  end

  assign idle_now     = (idle_q == IDLE);
  assign idle_next    = (idle_d == IDLE);
  assign bus.IDLE_ACK = idle_now;
`else
  logic unused_idle_inputs;
  assign unused_idle_inputs = bus.IDL | bus.WAKE;
  assign idle_now     = 1'b0;
  assign idle_next    = 1'b0;
  assign bus.IDLE_ACK = 1'b0;
`endif

  // The counter also holds on the WAKE edge, so the first clock after idle
  // is S1P1 again with INSTR_START set.
  assign freeze = idle_now;

  mc_phase_ctr u_phase_ctr (
    .clk      (CLK),
    .rst_n    (RSTdash),
    .freeze   (freeze),
    .cnt      (cnt),
    .wrap     (wrap),
    .next_cnt (next_cnt)
  );

  always_comb begin
    cyc_d  = cyc_q;
    ncyc_d = ncyc_q;
    movx_d = movx_q;

    if (wrap) cyc_d = (cyc_q == ncyc_q) ? '0 : cyc_q + 1'b1;

    if (!freeze && (cnt == NCYC_LATCH_CNT) && (cyc_q == '0)) begin
      ncyc_d = bus.NCYC;
      movx_d = bus.MOVX;
    end

    // Entering S1P1 of cycle 0 re-arms to a 1-cycle non-MOVX default, which
    // is why LAST_CYC reads 1 through S1/S2 of every first cycle.
    if ((next_cnt == '0) && (cyc_d == '0)) begin
      ncyc_d = '0;
      movx_d = 1'b0;
    end

    state_d  = cnt_to_state(next_cnt);
    p2_d     = next_cnt[0];
    last_d   = (cyc_d == ncyc_d);
    istart_d = (next_cnt == '0) && (cyc_d == '0) && !idle_next;

    ale_d = in_slot(next_cnt, ALE_SLOT_A) || in_slot(next_cnt, ALE_SLOT_B);
    // A multi-cycle MOVX uses the bus for the external data access, so the
    // second pulse of cycle 0 and the first pulse of cycle 1 are dropped.
    if (movx_d && (ncyc_d != '0)) begin
      if (((cyc_d == '0) && in_slot(next_cnt, ALE_SLOT_B)) ||
          ((cyc_d == CYC_W'(1)) && in_slot(next_cnt, ALE_SLOT_A))) begin
        ale_d = 1'b0;
      end
    end
    if (idle_next) ale_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      cyc_q    <= '0;
      ncyc_q   <= '0;
      movx_q   <= 1'b0;
      state_q  <= S1;
      p2_q     <= 1'b0;
      ale_q    <= 1'b0;
      last_q   <= 1'b1;
      istart_q <= 1'b1;
    end else begin
      cyc_q    <= cyc_d;
      ncyc_q   <= ncyc_d;
      movx_q   <= movx_d;
      state_q  <= state_d;
      p2_q     <= p2_d;
      ale_q    <= ale_d;
      last_q   <= last_d;
      istart_q <= istart_d;
    end
  end

  assign bus.STATE       = state_q;
  assign bus.P2          = p2_q;
  assign bus.ALE         = ale_q;
  assign bus.CYC         = cyc_q;
  assign bus.LAST_CYC    = last_q;
  assign bus.INSTR_START = istart_q;

endmodule

// File: tb/tb_mc_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_mc_timing_gen
// Self-checking bench for mc_timing_gen. The expected outputs are derived from
// the clock position k inside the current instruction (k = 0 .. 12*L-1) and
// the instruction's length and MOVX flag. Build with MCS51_IDLE_EN to include
// the idle-mode steps.
// -----------------------------------------------------------------------------
module tb_mc_timing_gen;

  logic CLK = 1'b0;
  logic RSTdash = 1'b0;

  mc_timing_gen_if bus ();

  mc_timing_gen dut (
    .CLK     (CLK),
    .RSTdash (RSTdash),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int tests   = 0;
  int fails   = 0;
  int k       = 0;   // clock position within current instruction
  int cur_l   = 1;   // machine cycles in current instruction
  bit cur_movx = 1'b0;
  int instr_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [5:0] st, input logic p2,
                         input logic ale, input logic [1:0] cyc, input logic last,
                         input logic is, input logic ack);
    chk({tag, ".STATE"},       32'(bus.STATE),       32'(st));
    chk({tag, ".P2"},          32'(bus.P2),          32'(p2));
    chk({tag, ".ALE"},         32'(bus.ALE),         32'(ale));
    chk({tag, ".CYC"},         32'(bus.CYC),         32'(cyc));
    chk({tag, ".LAST_CYC"},    32'(bus.LAST_CYC),    32'(last));
    chk({tag, ".INSTR_START"}, 32'(bus.INSTR_START), 32'(is));
    chk({tag, ".IDLE_ACK"},    32'(bus.IDLE_ACK),    32'(ack));
  endtask

  // Reference: position k -> expected outputs
  task automatic chk_model();
    int c  = k % 12;
    int cy = k / 12;
    bit slot_a = (c == 1) || (c == 2);
    bit slot_b = (c == 7) || (c == 8);
    bit ale    = slot_a || slot_b;
    bit last   = (k < 4) ? 1'b1 : (cy == cur_l - 1);
    if (cur_movx && (cur_l > 1) && (((cy == 0) && slot_b) || ((cy == 1) && slot_a)))
      ale = 1'b0;
    chk_vec("run", 6'(1 << (c / 2)), 1'(c % 2), ale, 2'(cy), last, k == 0, 1'b0);
  endtask

  task automatic reset_vals(input string tag);
    chk_vec(tag, 6'b000001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic edge_adv();
    @(posedge CLK);
    #1;
  endtask

  // Inputs for the coming edge: the instruction's NCYC/MOVX only at the
  // sampling point, noise everywhere else.
  task automatic drive_run();
    if (k == 3) begin
      bus.NCYC = 2'(cur_l - 1);
      bus.MOVX = cur_movx;
    end else begin
      bus.NCYC = 2'($urandom);
      bus.MOVX = 1'($urandom);
    end
`ifdef MCS51_IDLE_EN
    bus.IDL = 1'b0;
`else
    bus.IDL = 1'($urandom);
`endif
    bus.WAKE = 1'($urandom);
  endtask

  // Runs one instruction from k=0; stop_k >= 0 returns early at that position.
  task automatic run_instr(input int ncyc, input bit movx, input int stop_k);
    int ale_clks = 0;
    cur_l    = ncyc + 1;
    cur_movx = movx;
    instr_n++;
    $display("[TB] instr %0d ncyc=%0d movx=%0d stop_k=%0d", instr_n, ncyc, movx, stop_k);
    for (int i = 0; i < 12 * cur_l; i++) begin
      if ((stop_k >= 0) && (k == stop_k)) return;
      drive_run();
      edge_adv();
      k = (k + 1) % (12 * cur_l);
      ale_clks += int'(bus.ALE);
      chk_model();
    end
    chk("ale_clks", 32'(ale_clks), 32'(4 * cur_l - ((movx && cur_l > 1) ? 4 : 0)));
  endtask

  initial begin
    bus.NCYC = '0;
    bus.MOVX = 1'b0;
    bus.IDL  = 1'b0;
    bus.WAKE = 1'b0;
    RSTdash  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset_vals("reset");
    @(negedge CLK);
    RSTdash = 1'b1;
    k = 0;

    // Single-cycle instructions
    repeat (3) run_instr(0, 1'b0, -1);
    // Two-cycle instructions
    repeat (2) run_instr(1, 1'b0, -1);
    // MOVX suppression and its no-effect case
    run_instr(1, 1'b1, -1);
    run_instr(0, 1'b1, -1);
    run_instr(3, 1'b1, -1);
    run_instr(2, 1'b1, -1);
    run_instr(3, 1'b0, -1);
    // Random instruction mix
    repeat (40) run_instr(int'($urandom_range(0, 3)), 1'($urandom), -1);

    // Async reset at S4P1 of cycle 1 of a 4-cycle instruction
    run_instr(3, 1'b0, 18);
    RSTdash = 1'b0;
    #1;
    reset_vals("async_rst");
    edge_adv();
    reset_vals("rst_hold");
    RSTdash = 1'b1;
    k = 0;
    run_instr(3, 1'b0, -1);
    run_instr(1, 1'b1, -1);

`ifdef MCS51_IDLE_EN
    // IDL together with WAKE at the end of an instruction: idle not entered
    run_instr(0, 1'b0, 11);
    bus.IDL  = 1'b1;
    bus.WAKE = 1'b1;
    edge_adv();
    k = 0;
    chk_model();
    // Idle entry from the last cycle of a 2-cycle instruction
    run_instr(1, 1'b0, 23);
    bus.IDL  = 1'b1;
    bus.WAKE = 1'b0;
    edge_adv();
    chk_vec("idle", 6'b000001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      bus.IDL  = 1'($urandom);
      bus.NCYC = 2'($urandom);
      bus.MOVX = 1'($urandom);
      bus.WAKE = 1'b0;
      edge_adv();
      chk_vec("idle", 6'b000001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    end
    bus.WAKE = 1'b1;
    edge_adv();
    k = 0;
    chk_vec("wake", 6'b000001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    run_instr(1, 1'b1, -1);
    run_instr(0, 1'b0, -1);
`endif

    repeat (5) run_instr(int'($urandom_range(0, 3)), 1'($urandom), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
